// File: rtl/change_payout_ctrl.sv
// Change payout sequencer: greedy 20/10/5 coin ejection with timed strobes and per-tube inventory.
// Define PAYOUT_AUDIT_EN to add the total_paid / short_events audit counters.
module change_payout_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INV_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [7:0]       req_amount,
  output logic             req_ready,
  input  logic             load_en,
  input  logic [1:0]       load_sel,
  input  logic [INV_W-1:0] load_count,
  output logic             eject_05,
  output logic             eject_10,
  output logic             eject_20,
  output logic             busy,
  output logic             done,
  output logic [7:0]       shortfall,
  output logic [INV_W-1:0] inv_05,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_20
`ifdef PAYOUT_AUDIT_EN
  ,
  output logic [15:0]      total_paid,
  output logic [7:0]       short_events
`endif
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  localparam int CNT_W = 16;

  state_t                     state_q, state_d;
  logic [7:0]                 remaining_q, remaining_d;
  logic [7:0]                 shortfall_q, shortfall_d;
  logic [2:0][INV_W-1:0]      inv_q, inv_d;       // index 0=5, 1=10, 2=20
  logic [1:0]                 sel_q, sel_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 eject_q, eject_d;
  logic                       found;
  logic [1:0]                 pick;

  function automatic logic [7:0] coin_value(input logic [1:0] sel);
    case (sel)
      2'd2:    coin_value = 8'd20;
      2'd1:    coin_value = 8'd10;
      default: coin_value = 8'd5;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !load_en;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    inv_d       = inv_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    found       = 1'b0;
    pick        = 2'd0;

    case (state_q)
      IDLE: begin
        if (load_en && load_sel != 2'd3) inv_d[load_sel] = load_count;
        if (req_valid && req_ready) begin
          remaining_d = req_amount;
          shortfall_d = 8'd0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        // Largest coin that fits and is in stock; residues below 5 fall through to shortfall.
        if (remaining_q >= 8'd20 && inv_q[2] != '0) begin
          found = 1'b1; pick = 2'd2;
        end else if (remaining_q >= 8'd10 && inv_q[1] != '0) begin
          found = 1'b1; pick = 2'd1;
        end else if (remaining_q >= 8'd5 && inv_q[0] != '0) begin
          found = 1'b1; pick = 2'd0;
        end
        if (found) begin
          remaining_d = remaining_q - coin_value(pick);
          inv_d[pick] = inv_q[pick] - INV_W'(1);
          sel_d       = pick;
          cnt_d       = '0;
          state_d     = PULSE;
        end else begin
          shortfall_d = remaining_q;
          remaining_d = 8'd0;
          state_d     = DONE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    eject_d = (state_d == PULSE) ? (3'b001 << sel_d) : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
      shortfall_q <= 8'd0;
      inv_q       <= '0;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      eject_q     <= 3'b000;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      inv_q       <= inv_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      eject_q     <= eject_d;
    end
  end

  assign eject_05  = eject_q[0];
  assign eject_10  = eject_q[1];
  assign eject_20  = eject_q[2];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign shortfall = shortfall_q;
  assign inv_05    = inv_q[0];
  assign inv_10    = inv_q[1];
  assign inv_20    = inv_q[2];

`ifdef PAYOUT_AUDIT_EN
  logic [15:0] total_paid_q;
  logic [7:0]  short_events_q;
  logic [16:0] paid_sum;

  assign paid_sum = {1'b0, total_paid_q} + 17'(coin_value(sel_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_paid_q   <= 16'd0;
      short_events_q <= 8'd0;
    end else begin
      if (state_q == SELECT && state_d == PULSE)
        total_paid_q <= paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
      if (state_q == DONE && shortfall_q != 8'd0 && short_events_q != 8'hFF)
        short_events_q <= short_events_q + 8'd1;
    end
  end

  assign total_paid   = total_paid_q;
  assign short_events = short_events_q;
`endif

endmodule

// File: doc/change_payout_ctrl.md
Name: change_payout_ctrl

Overview:
- Sequences physical coin ejection for change owed after a vend.
- Accepts a change amount in rupees over a valid/ready handshake and tracks per-denomination coin inventory (20/10/5).
- Pays out greedily, largest coin first, one timed eject pulse per coin; reports any unpayable remainder as shortfall.
- Sits between the vend logic's change output and the coin hopper drivers.

Parameters:
- PULSE_CYCLES, 4: cycles each eject strobe stays high (min 1).
- GAP_CYCLES, 2: idle cycles between consecutive coin ejects (min 1).
- INV_W, 8: width of each inventory counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  change request present.
- req_amount  in  8  change owed, rupees.
- req_ready  out  1  controller can accept a request.
- load_en  in  1  inventory load strobe.
- load_sel  in  2  0=5-rupee coin, 1=10-rupee coin, 2=20-rupee coin, 3=ignored.
- load_count  in  INV_W  new count for the selected coin tube.
- eject_05, eject_10, eject_20  out  1 each  hopper eject strobes.
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse when a payout finishes.
- shortfall  out  8  rupees not paid by the last payout.
- inv_05, inv_10, inv_20  out  INV_W each  current coin counts.

Behaviour:
- Reset values (async):
  - state=IDLE.
  - All eject strobes, done, busy and shortfall = 0.
  - inv_* = 0; remaining = 0.
  - Reset mid-payout aborts immediately; no further ejects.
- Handshake: req_ready = (state==IDLE) && !load_en. Accept on the rising edge where req_valid && req_ready. At accept, remaining<=req_amount, shortfall<=0, state->SELECT.
- Load: when state==IDLE and load_en, inv[load_sel]<=load_count (overwrite, not add). Ignored when not IDLE. load_sel=3 is a no-op.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- SELECT (1 cycle): pick the largest coin c in {20,10,5} with c<=remaining and inv_c>0.
  - If found: remaining-=c, inv_c-=1, state->PULSE.
  - Else: shortfall<=remaining, remaining<=0, state->DONE.
- PULSE: the chosen eject_* is high (registered) for exactly PULSE_CYCLES cycles, then state->GAP. Only one eject strobe is ever high at a time.
- GAP: all ejects low for GAP_CYCLES cycles, then state->SELECT.
- DONE (1 cycle): done=1, then state->IDLE. shortfall holds until the next accept or reset.
- busy=1 in SELECT/PULSE/GAP/DONE, 0 in IDLE.
- req_amount=0: SELECT finds no coin; DONE with shortfall=0, zero ejects.
- Amounts not a multiple of 5: the residue (1-4) always ends in shortfall.
- Inventory never underflows; a decrement occurs only when inv>0.
- Timing, accept at edge 0 with a single-coin payout:
  - SELECT in cycle 1.
  - Eject high in cycles 2..(1+PULSE_CYCLES).
  - GAP follows, then SELECT, then DONE.
  - req_ready high again the cycle after DONE.

Optional Feature:
- Macro PAYOUT_AUDIT_EN.
- Defined:
  - Adds output total_paid[15:0], a count of rupees ejected since reset. It increments by the coin value on SELECT->PULSE and saturates at 16'hFFFF.
  - Adds output short_events[7:0], incremented (saturating) on each DONE with nonzero shortfall.
  - Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Load inv_20=2, inv_10=2, inv_05=2; request 35 -> eject_20, eject_10, eject_05 once each in that order; shortfall=0; inv=1/1/1; done pulses once.
- Load inv_20=0, inv_10=1, inv_05=1; request 40 -> eject_10 then eject_05; shortfall=25; inv=0/0/0.
- Request 7 with ample inventory -> one eject_05, shortfall=2. Request 0 -> no ejects, done after SELECT, shortfall=0.
- Default params, request 20 accepted at edge 0 -> eject_20 high cycles 2-5, low cycles 6-7, SELECT at 8, done at 9, req_ready at 10.
- load_en with req_valid in IDLE -> load applied, request not accepted that cycle; load_en during PULSE -> inventory unchanged.
- Assert reset during the second coin's PULSE -> ejects drop the same cycle; inv=0, shortfall=0, busy=0, req_ready=1 after release.
